// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder: operation encoding and the
// WIDTH/STAGES legality rule.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // A configuration is legal when the word is at least two bits wide and the
    // stage count splits it into equal slices.
    function automatic logic cfg_legal(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One W-bit ripple-carry slice: sum and carry-out of a + b + carry_i.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] c_s;

    assign c_s[0] = carry_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
        assign c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end

    assign carry_o = c_s[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready handshake. The word is split
// into STAGES equal slices; stage k adds slice k with the carry registered by
// stage k-1. Operand slices not yet consumed travel forward in skew registers
// that shrink stage by stage, and finished sum slices accumulate in deskew
// registers that grow, so the last stage holds one complete transaction.
module pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int WS = WIDTH / STAGES;

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic             stall_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;

    // Subtraction is A + ~B + 1; cin only matters for addition.
    assign b_eff_s  = (op_e'(sub) == OP_SUB) ? ~B : B;
    assign c_eff_s  = (op_e'(sub) == OP_SUB) ? 1'b1 : cin;

    // The whole pipe freezes while a finished result waits for the consumer.
    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int  REM  = WIDTH - k * WS;
        localparam bit  LAST = (k == STAGES - 1);

        logic [REM-1:0]        a_in_s;
        logic [REM-1:0]        b_in_s;
        logic                  c_in_s;
        logic                  v_in_s;
        logic [WS-1:0]         slice_s;
        logic                  carry_s;
        logic [(k+1)*WS-1:0]   sum_d;
        logic [(k+1)*WS-1:0]   sum_q;
        logic                  carry_q;
        logic                  valid_q;

        if (k == 0) begin : g_head
            assign a_in_s = A;
            assign b_in_s = b_eff_s;
            assign c_in_s = c_eff_s;
            assign v_in_s = in_valid;
            assign sum_d  = slice_s;
        end else begin : g_body
            assign a_in_s = g_stage[k-1].g_skew.a_q;
            assign b_in_s = g_stage[k-1].g_skew.b_q;
            assign c_in_s = g_stage[k-1].carry_q;
            assign v_in_s = g_stage[k-1].valid_q;
            assign sum_d  = {slice_s, g_stage[k-1].sum_q};
        end

        adder_slice #(
            .W (WS)
        ) u_slice (
            .a_i     (a_in_s[WS-1:0]),
            .b_i     (b_in_s[WS-1:0]),
            .carry_i (c_in_s),
            .sum_o   (slice_s),
            .carry_o (carry_s)
        );

        // Stage valid, carry and deskewed sum: cleared by reset, held on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (!stall_s) begin
                valid_q <= v_in_s;
                carry_q <= carry_s;
                sum_q   <= sum_d;
            end
        end

        if (!LAST) begin : g_skew
            logic [REM-WS-1:0] a_q;
            logic [REM-WS-1:0] b_q;

            // Carry the not-yet-added operand slices to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall_s) begin
                    a_q <= a_in_s[REM-1:WS];
                    b_q <= b_in_s[REM-1:WS];
                end
            end
        end else begin : g_tail
            logic ovf_q;

            // Overflow: equal effective operand signs with a differing sum sign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall_s) begin
                    ovf_q <= (a_in_s[REM-1] == b_in_s[REM-1]) &&
                             (slice_s[WS-1] != a_in_s[REM-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: reset, arithmetic vectors, back-to-back
// traffic with a stall, reset with work in flight, and a randomised sweep of
// the 16/4 and 8/1 configurations against a small reference model.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst, in_valid, cin, sub, out_ready;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic        rdy8, ov8, co8, of8;
    logic [7:0]  s8;
    logic        rdy16, ov16, co16, of16;
    logic [15:0] s16;
    logic        rdy1, ov1, co1, of1;
    logic [7:0]  s1;

    int checks = 0;
    int failures = 0;
    int cy = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .A(a8), .B(b8), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8)
    );

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .A(a16), .B(b16), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16)
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .A(a8), .B(b8), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
    );

    // Reference: {cout, ovf, sum}
    function automatic logic [9:0] m8(input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic s);
        logic [7:0] be;
        logic [8:0] r;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {8'd0, (s ? 1'b1 : c)};
        return {r[8], (a[7] == be[7]) && (r[7] != a[7]), r[7:0]};
    endfunction

    function automatic logic [17:0] m16(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
        logic [15:0] be;
        logic [16:0] r;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {16'd0, (s ? 1'b1 : c)};
        return {r[16], (a[15] == be[15]) && (r[15] != a[15]), r[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        cy++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b sum=%h cout=%b ovf=%b want all 0", ov8, s8, co8, of8);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", rdy8);
        end
        cyc();
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: out_valid got %b want 0", ov8);
        end
    endtask

    task automatic test_vec(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic s, input logic [7:0] es,
                            input logic ec, input logic eo);
        out_ready = 1'b1;
        a8 = a; b8 = b; cin = c; sub = s; in_valid = 1'b1;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready: got %b want 1", nm, rdy8);
        end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL %s_early: out_valid got %b want 0 after 1 cycle", nm, ov8);
        end
        cyc();
        checks++;
        if (ov8 !== 1'b1 || s8 !== es || co8 !== ec || of8 !== eo) begin
            failures++;
            $display("FAIL %s: got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                     nm, ov8, s8, co8, of8, es, ec, eo);
        end
        cyc();
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL %s_once: out_valid got %b want 0 after consume", nm, ov8);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  q[$];
        logic [10:0] held;
        logic        prev_stall, stall;
        int          sent, got, nstall;
        sent = 0; got = 0; nstall = 0; prev_stall = 1'b0; held = '0;
        cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 10);
            a8 = 8'(sent * 37);
            b8 = 8'(200 - sent * 13);
            #1;
            if (prev_stall) begin
                checks++;
                if ({ov8, co8, of8, s8} !== held) begin
                    failures++;
                    $display("FAIL b2b_stable: got %h want %h at cycle %0d", {ov8, co8, of8, s8}, held, c);
                end
            end
            stall = ov8 && !out_ready;
            if (stall) begin
                nstall++;
                checks++;
                if (rdy8 !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_in_ready: got %b want 0 during stall at cycle %0d", rdy8, c);
                end
            end
            if (ov8 === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious: result %h with nothing outstanding", s8);
                end else if ({co8, of8, s8} !== q[0]) begin
                    failures++;
                    $display("FAIL b2b_data: got %h want %h (result %0d)", {co8, of8, s8}, q[0], got);
                    void'(q.pop_front());
                end else begin
                    void'(q.pop_front());
                end
                got++;
            end
            if (in_valid && rdy8) begin
                q.push_back(m8(a8, b8, 1'b0, 1'b0));
                sent++;
            end
            prev_stall = stall;
            held = {ov8, co8, of8, s8};
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 10 || sent != 10 || q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: sent=%0d got=%0d left=%0d want 10/10/0", sent, got, q.size());
        end
        checks++;
        if (nstall != 4) begin
            failures++;
            $display("FAIL b2b_stall_cycles: got %0d want 4", nstall);
        end
        cyc();
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a8 = 8'h12; b8 = 8'h34; in_valid = 1'b1;
        cyc();
        a8 = 8'h40; b8 = 8'h02;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (ov8 !== 1'b1) begin
            failures++;
            $display("FAIL inflight_setup: out_valid got %b want 1", ov8);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
            failures++;
            $display("FAIL inflight_reset: got v=%b sum=%h cout=%b ovf=%b want all 0", ov8, s8, co8, of8);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (ov8 !== 1'b0) begin
                failures++;
                $display("FAIL inflight_ghost: out_valid got %b want 0 (cycle %0d)", ov8, i);
            end
        end
    endtask

    task automatic test_sweep();
        logic [9:0]  q8[$], q1[$];
        logic [17:0] q16[$];
        int          t8[$], t1[$], t16[$];
        logic [9:0]  e8;
        logic [17:0] e16;
        int          tg;
        out_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (ov16 === 1'b1) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL sweep16_spurious: result %h", s16);
                end else begin
                    e16 = q16.pop_front(); tg = t16.pop_front();
                    if ({co16, of16, s16} !== e16 || cy - tg != 4) begin
                        failures++;
                        $display("FAIL sweep16: got %h lat=%0d want %h lat=4", {co16, of16, s16}, cy - tg, e16);
                    end
                end
            end
            if (ov1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL sweep1_spurious: result %h", s1);
                end else begin
                    e8 = q1.pop_front(); tg = t1.pop_front();
                    if ({co1, of1, s1} !== e8 || cy - tg != 1) begin
                        failures++;
                        $display("FAIL sweep1: got %h lat=%0d want %h lat=1", {co1, of1, s1}, cy - tg, e8);
                    end
                end
            end
            if (ov8 === 1'b1) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL sweep8_spurious: result %h", s8);
                end else begin
                    e8 = q8.pop_front(); tg = t8.pop_front();
                    if ({co8, of8, s8} !== e8 || cy - tg != 2) begin
                        failures++;
                        $display("FAIL sweep8: got %h lat=%0d want %h lat=2", {co8, of8, s8}, cy - tg, e8);
                    end
                end
            end
            if (i < 40) begin
                in_valid = 1'b1;
                a8 = 8'($urandom); b8 = 8'($urandom);
                a16 = 16'($urandom); b16 = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                q8.push_back(m8(a8, b8, cin, sub));   t8.push_back(cy);
                q1.push_back(m8(a8, b8, cin, sub));   t1.push_back(cy);
                q16.push_back(m16(a16, b16, cin, sub)); t16.push_back(cy);
            end else begin
                in_valid = 1'b0;
            end
            cyc();
        end
        checks++;
        if (q8.size() != 0 || q1.size() != 0 || q16.size() != 0) begin
            failures++;
            $display("FAIL sweep_lost: left 8/2=%0d 8/1=%0d 16/4=%0d want 0", q8.size(), q1.size(), q16.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
        test_reset();
        test_vec("add_7b_a5",  8'h7B, 8'hA5, 1'b1, 1'b0, 8'h21, 1'b1, 1'b0);
        test_vec("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        test_vec("ovf_55_56",  8'h55, 8'h56, 1'b0, 1'b0, 8'hAB, 1'b0, 1'b1);
        test_vec("sub_05_07",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        test_vec("sub_cin_ign", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        test_vec("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_inflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2: pipeline depth; SHALL divide WIDTH exactly, giving slice width W_S = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  A, B, cin and sub carry a transaction this cycle.
REQ-006 in_ready  output  1  the pipe accepts the transaction this cycle.
REQ-007 A  input  WIDTH  first operand, unsigned or two's complement.
REQ-008 B  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in, used only when sub=0.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  sum, cout and ovf hold a completed result.
REQ-012 out_ready  input  1  the consumer takes the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out; for subtract, 1 means no borrow (A >= B unsigned).
REQ-015 ovf  output  1  two's-complement overflow of the operation.

Function
REQ-016 sub=0 SHALL compute {cout,sum} = A + B + cin; sub=1 SHALL compute {cout,sum} = A + ~B + 1, ignoring cin.
REQ-017 ovf SHALL be 1 exactly when both effective operand MSBs are equal and the sum MSB differs from them.
REQ-018 Stage k (0..STAGES-1) SHALL add slice k of the operands plus the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 Upper operand slices SHALL travel in skew registers, and completed lower sum slices in deskew registers, so every output bit belongs to the same transaction.
REQ-020 Latency SHALL be STAGES cycles from accept (in_valid && in_ready) to out_valid, with no stalls.
REQ-021 Throughput SHALL be one transaction per cycle when out_ready is held at 1.
REQ-022 Each stage SHALL hold a valid bit; bubbles SHALL propagate as invalid slots and never produce out_valid.
REQ-023 Stall = out_valid && !out_ready; while stalled, every stage SHALL hold its contents, in_ready SHALL be 0, and sum, cout and ovf SHALL stay stable.
REQ-024 in_ready = !stall; an input offered while in_ready=0 SHALL NOT be captured.
REQ-025 A result SHALL be consumed when out_valid && out_ready, and it SHALL be consumed exactly once.
REQ-026 Wrap-around: an all-ones sum plus 1 SHALL produce sum=0 and cout=1, with no exception state.

Reset
REQ-027 When rst=1 at a clock edge, all stage valid bits, out_valid, sum, cout and ovf SHALL become 0.
REQ-028 rst SHALL take priority over in_valid and over stall.
REQ-029 An in-flight transaction at reset SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-031 The operation encoding (ADD=0, SUB=1) and the STAGES | WIDTH legality check SHALL live in a shared package, alu_pkg.
REQ-032 One sub-module, adder_slice (W_S-bit ripple add with carry in and out), SHALL be instantiated once per stage; no other hierarchy.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-033 Input A=0x7B, B=0xA5, cin=1, sub=0 -> after 2 cycles: sum=0x21, cout=1, ovf=0.
REQ-034 Input A=0xFF, B=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0. Input A=0x55, B=0x56, cin=0, sub=0 -> sum=0xAB, cout=0, ovf=1.
REQ-035 Input A=0x05, B=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Input A=0x80, B=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-036 Ten back-to-back transactions with out_ready held low for cycles 3-6 -> in_ready=0 during the stall, no loss or duplication, results in order, outputs stable while stalled.
REQ-037 Assert rst while two transactions are in flight -> out_valid=0 the next cycle and neither result ever appears.
REQ-038 Random sweep at WIDTH=16, STAGES=4 and at WIDTH=8, STAGES=1 against a reference model -> zero mismatches, latency equal to STAGES.
